gold_b_checker: RTL and testbench

Receive-side companion to the Gold-code B-sequence generator. Takes the serial chip stream produced by a B generator (recurrence s[n] = s[n-cycleB20] XOR s[n-cycleB0]), self-synchronises by loading received chips into its own history register, then predicts each following chip and compares it with the received one. Reports lock status, per-chip errors and a running error count. Sits at the far end of the link from the generator, ahead of the despreader.

---
 rtl/gold_b_checker.sv | 169 ++++++++++++++++
 tb/tb_gold_b_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_b_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gold_b_checker
//  Purpose  : Receive-side checker for the Gold-code B sequence
//             s[n] = s[n-cycleB20] ^ s[n-cycleB0]. Self-synchronises by
//             loading received chips, verifies a run of predicted chips,
//             then flywheels on its own prediction, flagging chip errors,
//             counting them and dropping lock when a window has too many.
//  Revision : 1.0 - initial release
// ============================================================================
module gold_b_checker #(
  parameter int cycleB0    = 26,
  parameter int cycleB20   = 21,
  parameter int LOCK_CNT   = 32,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset_N,
  input  logic             Enable,
  input  logic             Chip_In,
  output logic             Locked,
  output logic             Chip_Err,
  output logic             Lock_Lost,
  output logic [CNT_W-1:0] Err_Count
);

  localparam int FILL_W  = $clog2(cycleB0 + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(ERR_THRESH + 2);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [cycleB0-1:0]   hist_q,      hist_d;
  logic [FILL_W-1:0]    fill_q,      fill_d;
  logic [MATCH_W-1:0]   match_q,     match_d;
  logic [WIN_W-1:0]     win_q,       win_d;
  logic [WERR_W-1:0]    werr_q,      werr_d;
  logic [CNT_W-1:0]     err_cnt_q,   err_cnt_d;
  logic                 locked_q,    locked_d;
  logic                 chip_err_q,  chip_err_d;
  logic                 lock_lost_q, lock_lost_d;

  // hist[0] is the newest chip, so tap k of the recurrence sits at index k-1
  logic w_pred;
  logic w_hist_nz;
  logic w_mismatch;

  assign w_pred     = hist_q[cycleB20-1] ^ hist_q[cycleB0-1];
  assign w_hist_nz  = |hist_q;
  assign w_mismatch = Chip_In ^ w_pred;

  // Next-state and output decode; only enabled chips advance anything
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_cnt_d   = err_cnt_q;
    chip_err_d  = 1'b0;
    lock_lost_d = 1'b0;

    if (Enable) begin
      unique case (state_q)
        ST_LOAD: begin
          hist_d = {hist_q[cycleB0-2:0], Chip_In};
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_W'(cycleB0 - 1)) begin
            state_d = ST_CHECK;
            match_d = '0;
          end
        end

        ST_CHECK: begin
          hist_d = {hist_q[cycleB0-2:0], Chip_In};
          if (w_mismatch) begin
            // Any disagreement means the loaded history is untrustworthy
            state_d = ST_LOAD;
            fill_d  = '0;
          end else if (!w_hist_nz) begin
            // The all-zero sequence trivially self-predicts; refuse to lock on it
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = ST_LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end
          end
        end

        ST_LOCKED: begin
          // Flywheel: history follows our own prediction, not the line
          hist_d = {hist_q[cycleB0-2:0], w_pred};
          if (w_mismatch) begin
            chip_err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end

          if (w_mismatch && (werr_q == WERR_W'(ERR_THRESH))) begin
            state_d     = ST_LOAD;
            fill_d      = '0;
            lock_lost_d = 1'b1;
            werr_d      = werr_q + 1'b1;
          end else if (win_q == WIN_W'(WINDOW - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + WERR_W'(w_mismatch);
          end
        end

        default: begin
          state_d = ST_LOAD;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, history, counters and registered outputs
  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_q     <= ST_LOAD;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      chip_err_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      chip_err_q  <= chip_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign Locked    = locked_q;
  assign Chip_Err  = chip_err_q;
  assign Lock_Lost = lock_lost_q;
  assign Err_Count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gold_b_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gold_b_checker
//  Purpose  : Self-checking bench for gold_b_checker: generator-driven
//             streams with injected chip errors, Enable gaps and resets,
//             compared against a chip-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gold_b_checker;

  localparam int B0     = 26;
  localparam int B20    = 21;
  localparam int LOCKN  = 32;
  localparam int WIN    = 64;
  localparam int THRESH = 8;
  localparam int CW     = 16;

  logic          Clock   = 1'b0;
  logic          Reset_N = 1'b0;
  logic          Enable  = 1'b0;
  logic          Chip_In = 1'b0;
  logic          Locked;
  logic          Chip_Err;
  logic          Lock_Lost;
  logic [CW-1:0] Err_Count;

  gold_b_checker #(
    .cycleB0   (B0),
    .cycleB20  (B20),
    .LOCK_CNT  (LOCKN),
    .WINDOW    (WIN),
    .ERR_THRESH(THRESH),
    .CNT_W     (CW)
  ) dut (
    .Clock    (Clock),
    .Reset_N  (Reset_N),
    .Enable   (Enable),
    .Chip_In  (Chip_In),
    .Locked   (Locked),
    .Chip_Err (Chip_Err),
    .Lock_Lost(Lock_Lost),
    .Err_Count(Err_Count)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // ---------------- transmit-side generator ----------------
  bit g[B0];   // g[0] = most recent chip sent

  task automatic gen_seed();
    bit any = 0;
    while (!any) begin
      for (int i = 0; i < B0; i++) begin
        g[i] = 1'($urandom);
        any |= g[i];
      end
    end
  endtask

  task automatic gen_next(output bit c);
    c = g[B20-1] ^ g[B0-1];
    for (int i = B0 - 1; i > 0; i--) g[i] = g[i-1];
    g[0] = c;
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = acquiring (filling), 1 = verifying, 2 = locked
  int      m_mode, m_have, m_run, m_wpos, m_werr;
  bit      m_h[$];          // last received/predicted chips, front = newest
  bit      m_locked, m_err, m_lost;
  int      m_cnt;

  task automatic model_reset();
    m_mode = 0; m_have = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_h.delete();
    for (int i = 0; i < B0; i++) m_h.push_back(1'b0);
    m_locked = 0; m_err = 0; m_lost = 0; m_cnt = 0;
  endtask

  task automatic model_push(bit b);
    m_h.push_front(b);
    void'(m_h.pop_back());
  endtask

  task automatic model_chip(bit en, bit chip);
    bit p;
    bit zero;
    m_err  = 0;
    m_lost = 0;
    if (en) begin
      p    = m_h[B20-1] ^ m_h[B0-1];
      zero = !(1'b1 inside {m_h});
      if (m_mode == 0) begin
        model_push(chip);
        m_have++;
        if (m_have == B0) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        model_push(chip);
        if (chip != p) begin
          m_mode = 0; m_have = 0;
        end else if (zero) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == LOCKN) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
        end
      end else begin
        model_push(p);
        if (chip != p) begin
          m_err = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_werr++;
        end
        if (m_werr > THRESH) begin
          m_lost = 1; m_mode = 0; m_have = 0;
        end else begin
          m_wpos++;
          if (m_wpos == WIN) begin m_wpos = 0; m_werr = 0; end
        end
      end
    end
    m_locked = (m_mode == 2);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("model_locked",    32'(Locked),    32'(m_locked));
    chk("model_chip_err",  32'(Chip_Err),  32'(m_err));
    chk("model_lock_lost", 32'(Lock_Lost), 32'(m_lost));
    chk("model_err_count", 32'(Err_Count), 32'(m_cnt));
  endtask

  task automatic step(bit en, bit chip);
    Enable  = en;
    Chip_In = chip;
    @(posedge Clock);
    #1;
    model_chip(en, chip);
    cmp_all();
  endtask

  task automatic send(bit invert);
    bit c;
    gen_next(c);
    step(1'b1, c ^ invert);
  endtask

  task automatic send_n(int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    Enable  = 1'b1;
    Chip_In = 1'($urandom);
    @(posedge Clock);
    #1;
    Reset_N = 1'b1;
    model_reset();
    cmp_all();
    chk("reset_locked",    32'(Locked),    32'd0);
    chk("reset_chip_err",  32'(Chip_Err),  32'd0);
    chk("reset_lock_lost", 32'(Lock_Lost), 32'd0);
    chk("reset_err_count", 32'(Err_Count), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit c;
    bit ever;

    model_reset();
    do_reset();

    // Acquisition: locked exactly after enabled chip 58
    gen_seed();
    send_n(B0 + LOCKN - 1);
    chk("acq_before_58", 32'(Locked), 32'd0);
    send(1'b0);
    chk("acq_at_58", 32'(Locked), 32'd1);

    // Clean flywheel run
    send_n(1000);
    chk("clean_err_count", 32'(Err_Count), 32'd0);
    chk("clean_locked", 32'(Locked), 32'd1);

    // Single inverted chip
    send(1'b1);
    chk("single_chip_err", 32'(Chip_Err), 32'd1);
    chk("single_locked", 32'(Locked), 32'd1);
    send(1'b0);
    chk("single_pulse_end", 32'(Chip_Err), 32'd0);
    chk("single_err_count", 32'(Err_Count), 32'd1);
    send_n(WIN);

    // Eight errors in every window over three windows keeps lock
    for (int i = 0; i < 3 * WIN; i++) send((i % 8) == 0);
    chk("eight_per_window_locked", 32'(Locked), 32'd1);
    chk("eight_per_window_count", 32'(Err_Count), 32'd25);

    // Nine errors inside one window loses lock on the ninth
    for (int i = 0; i < WIN && m_wpos != 0; i++) send(1'b0);
    for (int i = 0; i < THRESH + 1; i++) begin
      send(1'b1);
      chk("nine_chip_err", 32'(Chip_Err), 32'd1);
      chk("nine_lock_lost", 32'(Lock_Lost), (i == THRESH) ? 32'd1 : 32'd0);
      chk("nine_locked", 32'(Locked), (i == THRESH) ? 32'd0 : 32'd1);
    end
    send(1'b0);
    chk("nine_lost_pulse_end", 32'(Lock_Lost), 32'd0);

    // Mismatch at CHECK match count 10 restarts acquisition
    do_reset();
    gen_seed();
    send_n(B0 + 10);
    send(1'b1);
    send_n(B0 + LOCKN - 1);
    chk("check_restart_before", 32'(Locked), 32'd0);
    send(1'b0);
    chk("check_restart_lock", 32'(Locked), 32'd1);

    // All-zero stream never locks
    do_reset();
    ever = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0);
      ever |= Locked;
    end
    chk("all_zero_never_locked", 32'(ever), 32'd0);

    // Enable 1-in-3 with garbage on idle cycles
    do_reset();
    gen_seed();
    for (int i = 0; i < B0 + LOCKN; i++) begin
      if (i == B0 + LOCKN - 1) chk("sparse_before_58", 32'(Locked), 32'd0);
      send(1'b0);
      step(1'b0, 1'($urandom));
      step(1'b0, 1'($urandom));
    end
    chk("sparse_at_58", 32'(Locked), 32'd1);

    // Five errors then reset while locked
    for (int i = 0; i < 50; i++) send((i % 10) == 0);
    chk("pre_reset_count", 32'(Err_Count), 32'd5);
    chk("pre_reset_locked", 32'(Locked), 32'd1);
    do_reset();
    gen_seed();
    send_n(B0 + LOCKN);
    chk("reacquire_locked", 32'(Locked), 32'd1);

    // Random Enable and sparse random errors
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        gen_next(c);
        step(1'b1, c ^ ($urandom_range(0, 39) == 0));
      end else begin
        step(1'b0, 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
